mips_store_buffer: RTL and testbench

- Posted-write buffer sitting directly downstream of the single-cycle MIPS core's data-memory port.
- Captures stores (ALUResult as address, rt data as write data, MemWrite as valid) into a FIFO.
- Drains the FIFO to data memory through a valid/ack handshake, so a slow memory only stalls the core when the buffer is full.
- Forwards buffered store data to loads (MemRead) that hit a pending word.

---
 rtl/mips_store_buffer.sv | 199 +++++++++++++++++++
 tb/tb_mips_store_buffer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_store_buffer.sv
// mips_store_buffer
// Posted-write buffer between the MIPS core data-memory port and data memory.
// Stores are queued in a circular FIFO and drained to memory one at a time via
// a mem_we/mem_ack handshake; loads that hit a queued word get the newest data.
//
// Ports:
//   clk, reset                      - clock, synchronous active-low reset
//   st_valid/st_addr/st_data        - store from the core (MemWrite/ALUResult/rt)
//   st_ready, stall                 - buffer can accept / core must hold its PC
//   ld_valid/ld_addr                - load lookup from the core (MemRead)
//   ld_hit, ld_data                 - forwarding result (data is 0 on a miss)
//   mem_we/mem_addr/mem_wdata       - write request for the head entry
//   mem_ack                         - memory accepted the head write this cycle
//   count, empty, full              - occupancy status
//
// Optional feature macro: MIPS_STORE_BUFFER_COALESCE_EN
//   When defined, a store to the same word as the newest entry overwrites that
//   entry's data in place (also when full), unless that entry is the head
//   currently being written to memory.
module mips_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    st_valid,
    input  logic [ADDR_W-1:0]       st_addr,
    input  logic [DATA_W-1:0]       st_data,
    output logic                    st_ready,
    output logic                    stall,
    input  logic                    ld_valid,
    input  logic [ADDR_W-1:0]       ld_addr,
    output logic                    ld_hit,
    output logic [DATA_W-1:0]       ld_data,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic                    mem_ack,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty,
    output logic                    full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {IDLE = 1'b0, WRITE = 1'b1} state_t;

    // Word-granular address compare; byte offset bits are ignored.
    function automatic logic word_match(input logic [ADDR_W-1:0] a,
                                        input logic [ADDR_W-1:0] b);
        return (a[ADDR_W-1:2] == b[ADDR_W-1:2]);
    endfunction

    logic [ADDR_W-1:0] addr_mem_r [DEPTH];
    logic [DATA_W-1:0] data_mem_r [DEPTH];
    logic [DEPTH-1:0]  valid_r;
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_nxt_s;
    state_t            state_r;
    state_t            state_nxt_s;
    logic              full_s;
    logic              empty_s;
    logic              st_ready_s;
    logic              coalesce_s;
    logic              push_s;
    logic              pop_s;
    logic              mem_we_s;
    logic              fwd_hit_s;
    logic [DATA_W-1:0] fwd_data_s;

    assign full_s  = (count_r == CNT_W'(DEPTH));
    assign empty_s = (count_r == CNT_W'(0));

`ifdef MIPS_STORE_BUFFER_COALESCE_EN
    logic [PTR_W-1:0] newest_s;
    assign newest_s = tail_r - PTR_W'(1);
    // The head in WRITE is on the memory bus, so it must not be modified.
    assign coalesce_s = st_valid && !empty_s
                        && word_match(st_addr, addr_mem_r[newest_s])
                        && !((newest_s == head_r) && (state_r == WRITE));
    assign st_ready_s = !full_s || coalesce_s;
`else
    assign coalesce_s = 1'b0;
    assign st_ready_s = !full_s;
`endif

    assign push_s = st_valid && st_ready_s && !coalesce_s;
    assign pop_s  = (state_r == WRITE) && mem_ack;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO storage, pointers, valid bits and occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_r  <= PTR_W'(0);
            tail_r  <= PTR_W'(0);
            count_r <= CNT_W'(0);
            valid_r <= DEPTH'(0);
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_r[i] <= ADDR_W'(0);
                data_mem_r[i] <= DATA_W'(0);
            end
        end else begin
            if (push_s) begin
                addr_mem_r[tail_r] <= st_addr;
                data_mem_r[tail_r] <= st_data;
                valid_r[tail_r]    <= 1'b1;
                tail_r             <= tail_r + PTR_W'(1);
            end
`ifdef MIPS_STORE_BUFFER_COALESCE_EN
            if (coalesce_s) begin
                data_mem_r[newest_s] <= st_data;
            end
`endif
            // push and pop never share an index: pop needs count>=1, push needs count<DEPTH.
            if (pop_s) begin
                valid_r[head_r] <= 1'b0;
                head_r          <= head_r + PTR_W'(1);
            end
            count_r <= count_nxt_s;
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Drain FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (!empty_s) state_nxt_s = WRITE;
                else          state_nxt_s = IDLE;
            end
            WRITE: begin
                if (pop_s && (count_nxt_s == CNT_W'(0))) state_nxt_s = IDLE;
                else                                      state_nxt_s = WRITE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Drain FSM outputs.
    always_comb begin
        mem_we_s = 1'b0;
        case (state_r)
            IDLE:    mem_we_s = 1'b0;
            WRITE:   mem_we_s = 1'b1;
            default: mem_we_s = 1'b0;
        endcase
    end

    // Load forwarding: walk oldest to newest so the last match wins.
    always_comb begin
        logic [PTR_W-1:0] idx_s;
        fwd_hit_s  = 1'b0;
        fwd_data_s = DATA_W'(0);
        idx_s      = head_r;
        for (int i = 0; i < DEPTH; i++) begin
            idx_s = head_r + PTR_W'(i);
            if (ld_valid && valid_r[idx_s] && word_match(ld_addr, addr_mem_r[idx_s])) begin
                fwd_hit_s  = 1'b1;
                fwd_data_s = data_mem_r[idx_s];
            end else begin
                fwd_hit_s  = fwd_hit_s;
                fwd_data_s = fwd_data_s;
            end
        end
    end

    assign st_ready  = st_ready_s;
    assign stall     = st_valid && !st_ready_s;
    assign ld_hit    = fwd_hit_s;
    assign ld_data   = fwd_data_s;
    assign mem_we    = mem_we_s;
    assign mem_addr  = addr_mem_r[head_r];
    assign mem_wdata = data_mem_r[head_r];
    assign count     = count_r;
    assign empty     = empty_s;
    assign full      = full_s;

endmodule

// File: tb/tb_mips_store_buffer.sv
// Self-checking bench for mips_store_buffer (DEPTH=4, 32-bit address/data).
// Memory writes are checked against a scoreboard queue filled as stores are driven.
module tb_mips_store_buffer;
`ifdef MIPS_STORE_BUFFER_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = 32'h0;
    logic [31:0] st_data = 32'h0;
    logic        st_ready;
    logic        stall;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_addr = 32'h0;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] sb_q [$];

    typedef struct {
        logic        st_valid;
        logic [31:0] st_addr;
        logic [31:0] st_data;
        logic        ld_valid;
        logic [31:0] ld_addr;
        logic        mem_ack;
        logic        e_ready;
        logic        e_stall;
        logic        e_hit;
        logic [31:0] e_ldata;
        logic [2:0]  e_count;
        logic        e_full;
        logic        e_we;
    } vec_t;

    vec_t tbl [10];

    mips_store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .st_ready(st_ready), .stall(stall),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one store for a cycle and record what memory should eventually see.
    task automatic store(input logic [31:0] a, input logic [31:0] d, input bit coal);
        logic [63:0] t;
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        if (coal && sb_q.size() > 0) begin
            t = sb_q[sb_q.size()-1];
            t[31:0] = d;
            sb_q[sb_q.size()-1] = t;
        end else begin
            sb_q.push_back({a, d});
        end
        step();
        st_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        logic done_v;
        done_v  = 1'b0;
        mem_ack = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (empty && !mem_we) begin
                done_v = 1'b1;
                break;
            end
        end
        check(name, 64'(done_v), 64'h1);
        mem_ack = 1'b0;
    endtask

    // Every accepted memory write is compared against the scoreboard head.
    always @(negedge clk) begin
        logic [63:0] e;
        if (reset === 1'b1 && mem_we === 1'b1 && mem_ack === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none", mem_addr, mem_wdata);
            end else begin
                e = sb_q.pop_front();
                check("drain_addr", 64'(mem_addr), 64'(e[63:32]));
                check("drain_data", 64'(mem_wdata), 64'(e[31:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        // Fill-and-stall table; expectations are sampled before each row's clock edge.
        //           stv   st_addr   st_data   ldv   ld_addr  ack  rdy  stl  hit  ldata   cnt   full we
        tbl[0] = '{1'b1, 32'h100, 32'h11, 1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  3'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 32'h104, 32'h22, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  3'd1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 32'h108, 32'h33, 1'b0, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  3'd2, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 32'h10C, 32'h44, 1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  3'd3, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 32'h110, 32'h55, 1'b1, 32'h105, 1'b0, 1'b0, 1'b1, 1'b1, 32'h22, 3'd4, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 32'h0,   32'h0,  1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11, 3'd4, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 32'h114, 32'h66, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  3'd4, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 32'h0,   32'h0,  1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  3'd3, 1'b0, 1'b1};
        tbl[8] = '{1'b1, 32'h120, 32'h77, 1'b1, 32'h108, 1'b1, 1'b1, 1'b0, 1'b1, 32'h33, 3'd3, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 32'h0,   32'h0,  1'b1, 32'h120, 1'b0, 1'b1, 1'b0, 1'b1, 32'h77, 3'd3, 1'b0, 1'b1};

        // Reset held for three edges with a store pending.
        reset    = 1'b0;
        st_valid = 1'b1;
        st_addr  = 32'h40;
        st_data  = 32'hDEAD;
        repeat (3) @(posedge clk);
        #1;
        check("rst_count", 64'(count), 64'h0);
        check("rst_empty", 64'(empty), 64'h1);
        check("rst_full", 64'(full), 64'h0);
        check("rst_mem_we", 64'(mem_we), 64'h0);
        check("rst_ld_hit", 64'(ld_hit), 64'h0);
        check("rst_ld_data", 64'(ld_data), 64'h0);
        reset    = 1'b1;
        st_valid = 1'b0;
        #1;
        check("rst_st_ready", 64'(st_ready), 64'h1);
        step();

        // Single store with memory always acknowledging.
        mem_ack  = 1'b1;
        st_valid = 1'b1;
        st_addr  = 32'h10;
        st_data  = 32'hAABBCCDD;
        sb_q.push_back({32'h10, 32'hAABBCCDD});
        #1;
        check("single_ready", 64'(st_ready), 64'h1);
        check("single_stall", 64'(stall), 64'h0);
        step();
        st_valid = 1'b0;
        check("single_we_c1", 64'(mem_we), 64'h0);
        check("single_count", 64'(count), 64'h1);
        step();
        check("single_we_c2", 64'(mem_we), 64'h1);
        check("single_addr", 64'(mem_addr), 64'h10);
        check("single_wdata", 64'(mem_wdata), 64'hAABBCCDD);
        step();
        check("single_empty", 64'(empty), 64'h1);
        check("single_we_off", 64'(mem_we), 64'h0);
        mem_ack = 1'b0;

        // Table: fill, reject while full (also with a pop), forwarding, push+pop.
        for (int i = 0; i < 10; i++) begin
            st_valid = tbl[i].st_valid;
            st_addr  = tbl[i].st_addr;
            st_data  = tbl[i].st_data;
            ld_valid = tbl[i].ld_valid;
            ld_addr  = tbl[i].ld_addr;
            mem_ack  = tbl[i].mem_ack;
            if (tbl[i].st_valid && tbl[i].e_ready) sb_q.push_back({tbl[i].st_addr, tbl[i].st_data});
            @(negedge clk);
            check($sformatf("tbl%0d_ready", i), 64'(st_ready), 64'(tbl[i].e_ready));
            check($sformatf("tbl%0d_stall", i), 64'(stall), 64'(tbl[i].e_stall));
            check($sformatf("tbl%0d_hit", i), 64'(ld_hit), 64'(tbl[i].e_hit));
            check($sformatf("tbl%0d_ldata", i), 64'(ld_data), 64'(tbl[i].e_ldata));
            check($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].e_count));
            check($sformatf("tbl%0d_full", i), 64'(full), 64'(tbl[i].e_full));
            check($sformatf("tbl%0d_we", i), 64'(mem_we), 64'(tbl[i].e_we));
            step();
        end
        st_valid = 1'b0;
        ld_valid = 1'b0;
        mem_ack  = 1'b0;
        drain("tbl_drain_done");

        // Forwarding of the newest store to a word.
        store(32'h20, 32'h1, 1'b0);
        store(32'h20, 32'h2, COAL);
        ld_valid = 1'b1;
        ld_addr  = 32'h22;
        #1;
        check("fwd_hit", 64'(ld_hit), 64'h1);
        check("fwd_data", 64'(ld_data), 64'h2);
        check("fwd_count", 64'(count), COAL ? 64'h1 : 64'h2);
        ld_addr = 32'h24;
        #1;
        check("fwd_miss_hit", 64'(ld_hit), 64'h0);
        check("fwd_miss_data", 64'(ld_data), 64'h0);
        ld_valid = 1'b0;
        drain("fwd_drain_done");

        // Coalescing candidate pair.
        store(32'h30, 32'h5, 1'b0);
        store(32'h30, 32'h6, COAL);
        check("coal_count", 64'(count), COAL ? 64'h1 : 64'h2);
        drain("coal_drain_done");

        // Same word again once the head is already on the memory bus: always allocates.
        store(32'h40, 32'h7, 1'b0);
        step();
        check("nocoal_we", 64'(mem_we), 64'h1);
        store(32'h40, 32'h8, 1'b0);
        ld_valid = 1'b1;
        ld_addr  = 32'h40;
        #1;
        check("nocoal_count", 64'(count), 64'h2);
        check("nocoal_fwd", 64'(ld_data), 64'h8);
        ld_valid = 1'b0;
        drain("nocoal_drain_done");

        // Store to the newest word while full.
        store(32'h80, 32'h1, 1'b0);
        store(32'h84, 32'h2, 1'b0);
        store(32'h88, 32'h3, 1'b0);
        store(32'h8C, 32'h4, 1'b0);
        st_valid = 1'b1;
        st_addr  = 32'h8C;
        st_data  = 32'h99;
        if (COAL) begin
            sb_q.pop_back();
            sb_q.push_back({32'h8C, 32'h99});
        end
        #1;
        check("fullcoal_ready", 64'(st_ready), 64'(COAL));
        check("fullcoal_stall", 64'(stall), 64'(!COAL));
        step();
        st_valid = 1'b0;
        check("fullcoal_count", 64'(count), 64'h4);
        drain("fullcoal_drain_done");

        // Reset while draining drops every pending entry.
        store(32'h60, 32'hA, 1'b0);
        store(32'h64, 32'hB, 1'b0);
        store(32'h68, 32'hC, 1'b0);
        check("middrain_we", 64'(mem_we), 64'h1);
        check("middrain_count", 64'(count), 64'h3);
        reset   = 1'b0;
        mem_ack = 1'b1;
        sb_q.delete();
        step();
        check("middrain_rst_count", 64'(count), 64'h0);
        check("middrain_rst_we", 64'(mem_we), 64'h0);
        check("middrain_rst_empty", 64'(empty), 64'h1);
        reset = 1'b1;
        step();
        step();
        check("middrain_after_count", 64'(count), 64'h0);
        check("middrain_after_we", 64'(mem_we), 64'h0);
        mem_ack = 1'b0;
        step();

        check("sb_all_drained", 64'(sb_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
